// File: rtl/ras_pkg.sv
// Shared types and sizing for the committed return-address stack.
// The action struct bundles one commit's worth of stack work.
package ras_pkg;

  localparam int RAS_DEPTH      = 16;
  localparam int RAS_WIDTH      = 32;
  localparam int RAS_ADDR_WIDTH = 10;
  localparam int RAS_IDX_W      = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W      = RAS_IDX_W + 1;

  typedef struct packed {
    logic [RAS_WIDTH-1:0]      data;
    logic [RAS_ADDR_WIDTH-1:0] addr;
    logic                      pop;
    logic                      push;
  } ras_action_t;

endpackage

// File: rtl/ras_bram.sv
// Simple dual-port memory: port A registered read, port B write.
// Optional write-first bypass when both ports hit the same slot.
module ras_bram #(
  parameter int DEPTH           = 16,
  parameter int WIDTH           = 32,
  parameter int RESOLVE_COLLIDE = 1,
  localparam int IDX_W          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addra,
  output logic [WIDTH-1:0] douta,
  input  logic             web,
  input  logic [IDX_W-1:0] addrb,
  input  logic [WIDTH-1:0] dinb
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_douta;

  always_ff @(posedge clk) begin
    if (web) r_mem[addrb] <= dinb;
  end

  generate
    if (RESOLVE_COLLIDE != 0) begin : g_bypass
      always_ff @(posedge clk) begin
        r_douta <= (web && (addrb == addra)) ? dinb : r_mem[addra];
      end
    end else begin : g_plain
      always_ff @(posedge clk) begin
        r_douta <= r_mem[addra];
      end
    end
  endgenerate

  assign douta = r_douta;

endmodule

// File: rtl/ras_commit_stack.sv
// Architectural return-address stack fed by the committed action stream.
// Tracks committed tos/occupancy, serves fall-through lookups, drives recovery.
module ras_commit_stack
  import ras_pkg::*;
#(
  parameter int DEPTH      = RAS_DEPTH,
  parameter int WIDTH      = RAS_WIDTH,
  parameter int ADDR_WIDTH = RAS_ADDR_WIDTH,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  commit_i,
  input  logic                  pop_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  flush_i,
  output logic                  recover_valid_o,
  output logic [ADDR_WIDTH-1:0] base_addr_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CMP_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  ras_action_t           w_act;
  logic [ADDR_WIDTH-1:0] r_tos;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rd_valid;
  logic                  r_recover;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [ADDR_WIDTH-1:0] w_tos_next;
  logic [CNT_W-1:0]      w_count_next;
  logic                  w_overflow;
  logic                  w_underflow;
  logic                  w_web;
  logic [ADDR_WIDTH-1:0] w_dist;
  logic                  w_rd_valid_next;

  assign w_act = '{data: data_i, addr: addr_i, pop: pop_i, push: push_i};
  assign w_web = commit_i & w_act.push;

  // Pop-then-push: a paired pop/push replaces the top entry in place.
  always_comb begin
    w_tos_next   = r_tos;
    w_count_next = r_count;
    w_overflow   = 1'b0;
    w_underflow  = 1'b0;
    if (commit_i) begin
      case ({w_act.pop, w_act.push})
        2'b10: begin
          if (r_count != '0) begin
            w_tos_next   = r_tos - 1'b1;
            w_count_next = r_count - 1'b1;
          end else begin
            w_underflow = 1'b1;
          end
        end
        2'b01: begin
          w_tos_next = w_act.addr;
          if (r_count != FULL) w_count_next = r_count + 1'b1;
          else                 w_overflow   = 1'b1;
        end
        2'b11: begin
          w_tos_next = w_act.addr;
          if (r_count == '0) begin
            w_count_next = CNT_W'(1);
            w_underflow  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Validity uses post-commit state so it agrees with the write-first bypass.
  assign w_dist          = w_tos_next - rd_addr_i;
  assign w_rd_valid_next = ({1'b0, w_dist} < CMP_W'(w_count_next));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tos       <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_recover   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_tos       <= w_tos_next;
      r_count     <= w_count_next;
      r_rd_valid  <= w_rd_valid_next;
      r_recover   <= flush_i;
      r_overflow  <= w_overflow;
      r_underflow <= w_underflow;
    end
  end

  ras_bram #(
    .DEPTH          (DEPTH),
    .WIDTH          (WIDTH),
    .RESOLVE_COLLIDE(1)
  ) u_mem (
    .clk  (clk),
    .addra(rd_addr_i[IDX_W-1:0]),
    .douta(rd_data_o),
    .web  (w_web),
    .addrb(w_act.addr[IDX_W-1:0]),
    .dinb (w_act.data)
  );

  assign rd_valid_o      = r_rd_valid;
  assign recover_valid_o = r_recover;
  assign base_addr_o     = r_tos;
  assign count_o         = r_count;
  assign overflow_o      = r_overflow;
  assign underflow_o     = r_underflow;

endmodule

// File: tb/tb_ras_commit_stack.sv
// Directed and randomized checks of ras_commit_stack against a simple stack model.
module tb_ras_commit_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_i, pop_i, push_i, flush_i;
  logic [31:0] data_i;
  logic [9:0]  addr_i, rd_addr_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, recover_valid_o, overflow_o, underflow_o;
  logic [9:0]  base_addr_o;
  logic [4:0]  count_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference model: plain integers, mod arithmetic
  logic [31:0] m_mem [16];
  bit          m_known [16];
  int          m_tos, m_cnt;
  bit          exp_over, exp_under, exp_rec, exp_valid, exp_known;
  logic [31:0] exp_data;

  ras_commit_stack dut (
    .clk(clk), .reset(reset), .commit_i(commit_i), .pop_i(pop_i), .push_i(push_i),
    .data_i(data_i), .addr_i(addr_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .flush_i(flush_i), .recover_valid_o(recover_valid_o),
    .base_addr_o(base_addr_o), .count_o(count_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; commit_i = 0; pop_i = 0; push_i = 0; flush_i = 0;
    data_i = '0; addr_i = '0; rd_addr_i = '0;
    @(posedge clk); #1;
    m_tos = 0; m_cnt = 0;
    reset = 1'b0;
  endtask

  // One clock of stimulus; model state is advanced by the stack rules.
  task automatic drive(input bit c, input bit po, input bit pu, input logic [31:0] d,
                       input int a, input int ra, input bit fl);
    commit_i = c; pop_i = po; push_i = pu; data_i = d;
    addr_i = 10'(a); rd_addr_i = 10'(ra); flush_i = fl;
    exp_over = 0; exp_under = 0;
    if (c && po) begin
      if (m_cnt > 0) begin
        m_tos = (m_tos + 1023) % 1024;
        m_cnt = m_cnt - 1;
      end else if (!pu) begin
        exp_under = 1;
      end else begin
        exp_under = 1;
        m_cnt = -1; // empty pop: push below lands on an empty stack
      end
    end
    if (c && pu) begin
      m_mem[a % 16] = d;
      m_known[a % 16] = 1;
      m_tos = a % 1024;
      if (m_cnt < 0) m_cnt = 1;
      else if (po) m_cnt = m_cnt + 1;
      else if (m_cnt < 16) m_cnt = m_cnt + 1;
      else exp_over = 1;
    end
    exp_rec   = fl;
    exp_valid = (((m_tos - ra) % 1024 + 1024) % 1024) < m_cnt;
    exp_data  = m_mem[ra % 16];
    exp_known = m_known[ra % 16];
    @(posedge clk); #1;
    commit_i = 0; pop_i = 0; push_i = 0; flush_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tot_cnt++; if (count_o !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else pass_cnt++;
    tot_cnt++; if (base_addr_o !== 10'd0) $display("FAIL reset_base got=%0d exp=0", base_addr_o); else pass_cnt++;
    tot_cnt++; if (rd_valid_o !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid_o); else pass_cnt++;
    tot_cnt++; if ({recover_valid_o, overflow_o, underflow_o} !== 3'b000)
      $display("FAIL reset_pulses got=%b exp=000", {recover_valid_o, overflow_o, underflow_o}); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_push_read();
    do_reset();
    drive(1, 0, 1, 32'h100, 1, 0, 0);
    drive(1, 0, 1, 32'h200, 2, 0, 0);
    drive(0, 0, 0, 0, 0, 2, 0);
    tot_cnt++; if (rd_data_o !== 32'h200 || rd_valid_o !== 1'b1)
      $display("FAIL push_read_a2 got=%h/%b exp=200/1", rd_data_o, rd_valid_o); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 1, 0);
    tot_cnt++; if (rd_data_o !== 32'h100 || rd_valid_o !== 1'b1)
      $display("FAIL push_read_a1 got=%h/%b exp=100/1", rd_data_o, rd_valid_o); else pass_cnt++;
    tot_cnt++; if (count_o !== 5'd2 || base_addr_o !== 10'd2)
      $display("FAIL push_read_state got=%0d/%0d exp=2/2", count_o, base_addr_o); else pass_cnt++;
    $display("test_push_read done");
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0);
    tot_cnt++; if (underflow_o !== 1'b1 || count_o !== 5'd0 || base_addr_o !== 10'd0)
      $display("FAIL underflow_pop got=%b/%0d/%0d exp=1/0/0", underflow_o, count_o, base_addr_o); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    tot_cnt++; if (underflow_o !== 1'b0) $display("FAIL underflow_pulse_len got=%b exp=0", underflow_o); else pass_cnt++;
    drive(1, 1, 1, 32'h300, 5, 5, 0);
    tot_cnt++; if (underflow_o !== 1'b1 || count_o !== 5'd1 || base_addr_o !== 10'd5)
      $display("FAIL underflow_poppush got=%b/%0d/%0d exp=1/1/5", underflow_o, count_o, base_addr_o); else pass_cnt++;
    tot_cnt++; if (rd_data_o !== 32'h300 || rd_valid_o !== 1'b1)
      $display("FAIL underflow_poppush_rd got=%h/%b exp=300/1", rd_data_o, rd_valid_o); else pass_cnt++;
    $display("test_underflow done");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 32'h1000 + i, i, 0, 0);
      tot_cnt++; if (overflow_o !== 1'b0) $display("FAIL overflow_early i=%0d got=1 exp=0", i); else pass_cnt++;
    end
    drive(1, 0, 1, 32'h1010, 16, 0, 0);
    tot_cnt++; if (overflow_o !== 1'b1 || count_o !== 5'd16 || base_addr_o !== 10'd16)
      $display("FAIL overflow_17th got=%b/%0d/%0d exp=1/16/16", overflow_o, count_o, base_addr_o); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    tot_cnt++; if (overflow_o !== 1'b0 || rd_data_o !== 32'h1010)
      $display("FAIL overflow_alias got=%b/%h exp=0/1010", overflow_o, rd_data_o); else pass_cnt++;
    for (int a = 1; a <= 16; a++) begin
      drive(0, 0, 0, 0, 0, a, 0);
      tot_cnt++; if (rd_valid_o !== 1'b1) $display("FAIL overflow_valid a=%0d got=0 exp=1", a); else pass_cnt++;
    end
    $display("test_overflow done");
  endtask

  task automatic test_collide();
    drive(1, 0, 1, 32'hABC, 7, 7, 0);
    tot_cnt++; if (rd_data_o !== 32'hABC || rd_valid_o !== 1'b1)
      $display("FAIL collide got=%h/%b exp=abc/1", rd_data_o, rd_valid_o); else pass_cnt++;
    $display("test_collide done");
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 3; i++) drive(1, 0, 1, 32'h40 + i, i, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 1);
    tot_cnt++; if (recover_valid_o !== 1'b1 || base_addr_o !== 10'd2 || count_o !== 5'd2)
      $display("FAIL flush_pop got=%b/%0d/%0d exp=1/2/2", recover_valid_o, base_addr_o, count_o); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 1);
    tot_cnt++; if (recover_valid_o !== 1'b1) $display("FAIL flush_b2b got=0 exp=1"); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    tot_cnt++; if (recover_valid_o !== 1'b0) $display("FAIL flush_end got=1 exp=0"); else pass_cnt++;
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 32'h77 + i, i, 0, 0);
    do_reset();
    tot_cnt++; if (count_o !== 5'd0 || base_addr_o !== 10'd0)
      $display("FAIL reset_mid_state got=%0d/%0d exp=0/0", count_o, base_addr_o); else pass_cnt++;
    for (int a = 0; a < 4; a++) begin
      drive(0, 0, 0, 0, 0, a, 0);
      tot_cnt++; if (rd_valid_o !== 1'b0 || {recover_valid_o, overflow_o, underflow_o} !== 3'b000)
        $display("FAIL reset_mid_rd a=%0d got=%b/%b exp=0/000", a, rd_valid_o,
                 {recover_valid_o, overflow_o, underflow_o}); else pass_cnt++;
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int a, ra, errs;
    bit c, po, pu, fl;
    errs = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 9) < 7);
      po = $urandom_range(0, 2) == 0;
      pu = $urandom_range(0, 1) == 1;
      fl = $urandom_range(0, 7) == 0;
      a  = ($urandom_range(0, 9) < 7) ? (m_tos + 1) % 1024 : int'($urandom_range(0, 1023));
      ra = ($urandom_range(0, 3) != 0) ? (m_tos + 1024 - int'($urandom_range(0, 18))) % 1024
                                       : int'($urandom_range(0, 1023));
      drive(c, po, pu, $urandom, a, ra, fl);
      tot_cnt++;
      if (count_o !== 5'(m_cnt) || base_addr_o !== 10'(m_tos) || rd_valid_o !== exp_valid ||
          overflow_o !== exp_over || underflow_o !== exp_under || recover_valid_o !== exp_rec ||
          (exp_valid && exp_known && rd_data_o !== exp_data)) begin
        errs++;
        $display("FAIL random n=%0d got cnt=%0d tos=%0d v=%b ov=%b un=%b rec=%b d=%h exp cnt=%0d tos=%0d v=%b ov=%b un=%b rec=%b d=%h",
                 n, count_o, base_addr_o, rd_valid_o, overflow_o, underflow_o, recover_valid_o, rd_data_o,
                 m_cnt, m_tos, exp_valid, exp_over, exp_under, exp_rec, exp_data);
      end else pass_cnt++;
    end
    $display("test_random done, %0d cycles with errors", errs);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin m_known[i] = 0; m_mem[i] = '0; end
    test_reset();
    test_push_read();
    test_underflow();
    test_overflow();
    test_collide();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/ras_commit_stack.md
Name: ras_commit_stack

Overview:
- Architectural (committed) return-address stack directly downstream of the last speculative RAS stage.
- Consumes the committed action stream (data, addr, pop, push) that the stage FIFO releases on each commit.
- Holds non-speculative return addresses in a DEPTH-entry circular memory and tracks the committed top-of-stack pointer and occupancy.
- Serves lookup reads that fall through the speculative stages, and supplies the recovery base pointer on a pipeline flush.

Parameters:
- DEPTH, 16: committed entries; power of two.
- WIDTH, 32: return-address width.
- ADDR_WIDTH, 10: global stack-address width; memory index = low $clog2(DEPTH) bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- commit_i  in  1  one committed action presented this cycle; same strobe as the upstream stage commit.
- pop_i  in  1  committed action contains a pop.
- push_i  in  1  committed action contains a push.
- data_i  in  WIDTH  pushed return address.
- addr_i  in  ADDR_WIDTH  global slot written by the push.
- rd_addr_i  in  ADDR_WIDTH  lookup address, read every cycle.
- rd_data_o  out  WIDTH  lookup data, 1-cycle latency.
- rd_valid_o  out  1  lookup slot lies inside committed occupancy, aligned with rd_data_o.
- flush_i  in  1  misprediction flush request.
- recover_valid_o  out  1  one-cycle pulse carrying the recovery pointer.
- base_addr_o  out  ADDR_WIDTH  committed top-of-stack pointer (tos).
- count_o  out  $clog2(DEPTH)+1  committed occupancy, 0..DEPTH.
- overflow_o  out  1  pulse: a push was committed while count == DEPTH.
- underflow_o  out  1  pulse: a pop was committed while count == 0.

Behaviour:
- Reset values: tos = 0, count = 0, recover_valid_o = 0, overflow_o = 0, underflow_o = 0, rd_valid_o = 0. rd_data_o is don't-care until the first read after reset.
- Reset mid-operation discards all state. Memory contents are not cleared; count = 0 makes every read invalid.
- Commit with commit_i=1 updates state at the clock edge. A pop/push pair is applied as pop-then-push:
  - pop only: if count > 0, tos <= tos - 1 (mod 2^ADDR_WIDTH) and count - 1. Else tos and count are unchanged and underflow_o pulses next cycle.
  - push only: mem[addr_i mod DEPTH] <= data_i, tos <= addr_i. If count < DEPTH, count + 1; else count stays DEPTH (oldest entry silently overwritten by wrap) and overflow_o pulses.
  - pop and push: write as for push, tos <= addr_i. Count is unchanged if count > 0, else becomes 1 and underflow_o pulses.
  - neither bit set, or commit_i=0: no state change.
- Read port:
  - rd_addr_i is sampled every cycle; rd_data_o = mem[rd_addr_i mod DEPTH] one cycle later.
  - Same-cycle collision: a read of the slot being written by a committed push returns the new data_i (write-first bypass).
  - rd_valid_o = registered ((tos - rd_addr_i) mod 2^ADDR_WIDTH < count), computed against post-commit tos/count so it agrees with the bypass.
- Recovery:
  - flush_i=1 -> next cycle recover_valid_o=1 and base_addr_o = post-commit tos. A commit in the same cycle as the flush is applied first.
  - Back-to-back flushes give back-to-back pulses.
  - base_addr_o is always the registered tos, whether or not a flush is in progress.
- Width rules: all pointer arithmetic wraps modulo 2^ADDR_WIDTH. The count comparator is $clog2(DEPTH)+1 bits wide so that count == DEPTH is representable.
- The block applies no back-pressure; every commit is accepted.

Decomposition:
- ras_pkg: ras_action_t packed struct {data, addr, pop, push} parameterised by WIDTH/ADDR_WIDTH, plus the localparam for index width.
- Sub-module: ras_bram with RESOLVE_COLLIDE=1.
  - Port A: read only.
  - Port B: write only, web = commit_i && push_i.
- Occupancy/pointer logic and the recovery pulse stay in the top module.

Test Plan:
- Push A=0x100 @addr 1, push B=0x200 @addr 2, then read rd_addr 2 and rd_addr 1 -> rd_data 0x200 then 0x100, both rd_valid=1; count_o=2, base_addr_o=2.
- Pop with count=0 -> underflow_o pulse, base_addr_o stays 0, count_o stays 0; then pop+push 0x300 @addr 5 -> count_o=1, base_addr_o=5, underflow_o pulses again.
- 17 pushes at addrs 0..16 with DEPTH=16 -> count_o saturates at 16, overflow_o pulses once on the 17th push; read addr 0 returns the 17th data (slot aliased), rd_valid=1 for addr 1..16.
- Commit push 0xABC @addr 7 while rd_addr_i=7 in the same cycle -> next cycle rd_data_o=0xABC, rd_valid_o=1.
- tos=3, count=3: flush_i together with a committed pop -> next cycle recover_valid_o=1, base_addr_o=2, count_o=2.
- Assert reset after 4 pushes -> count_o=0, base_addr_o=0, all reads rd_valid_o=0, no overflow/underflow/recover pulses.
